aes_block_packer: RTL and testbench
===================================

Name: aes_block_packer

Overview:
Upstream/downstream wrapper for the AES encryption core on the SD data path. It gathers 16 plaintext bytes from the SD byte stream into one 128-bit block. It then starts the core with a one-cycle enable pulse, tracks the core's busy signal to detect completion, and captures the 128-bit ciphertext. Finally it streams the ciphertext back out as 16 bytes under a valid/ready handshake.

Parameters:
NUM_BYTES, 16, bytes per block (fixed at 16 for AES-128; kept for bench clarity)
BUSY_TIMEOUT, 31, max cycles waiting for core busy to rise or fall before flagging error

Ports:
clk  in  1  clock
n_rst  in  1  reset, asynchronous, active-low
byte_in  in  8  plaintext byte from SD receive path
byte_in_valid  in  1  byte_in is valid this cycle
byte_in_ready  out  1  block accepts byte this cycle
enable_encrypt  out  1  one-cycle start pulse to encryption core
data_to_core  out  128  assembled plaintext block to core data input
enc_busy  in  1  core busy indicator
core_data_out  in  128  core ciphertext result
byte_out  out  8  ciphertext byte to SD transmit path
byte_out_valid  out  1  byte_out valid
byte_out_ready  in  1  downstream accepts byte_out
packer_busy  out  1  high in any state other than FILL
timeout_err  out  1  sticky error; cleared only by reset

Behaviour:
- Reset values: all outputs 0 (byte_in_ready=0 in the reset cycle); state FILL; byte index 0; plaintext and ciphertext registers 0.
- FSM states: FILL, START, WAIT_BUSY, WAIT_DONE, DRAIN, ERROR.
- FILL:
  - byte_in_ready=1.
  - Each byte_in_valid&&byte_in_ready cycle stores byte_in at plaintext[127-8*idx -: 8], so the first byte lands in [127:120] (FIPS-197 order); idx increments.
  - On the accept with idx==15: idx wraps to 0, go to START.
- START: enable_encrypt=1 for exactly this cycle; byte_in_ready=0; go to WAIT_BUSY.
- WAIT_BUSY:
  - enc_busy=1 -> WAIT_DONE.
  - Also accepts enc_busy already high in the START cycle (sampled next edge).
  - Timeout counter reaching BUSY_TIMEOUT -> ERROR.
- WAIT_DONE:
  - enc_busy=0 -> capture core_data_out into the ciphertext register on that edge; go to DRAIN.
  - Timeout counter reaching BUSY_TIMEOUT -> ERROR.
  - Timeout counter clears on every state change.
- DRAIN:
  - byte_out_valid=1; byte_out=cipher[127-8*idx -: 8].
  - On byte_out_ready: idx++.
  - On accept with idx==15: idx->0, go to FILL.
  - byte_out and byte_out_valid must stay stable while ready is low.
- ERROR: timeout_err=1; byte_in_ready=0; byte_out_valid=0; held until reset.
- data_to_core is driven from the plaintext register. It is stable from START until the next FILL accept, so it is constant throughout encryption.
- No overlap: input is not accepted during START/WAIT/DRAIN.
- byte_in_valid with byte_in_ready=0: the byte is not consumed, and the upstream holds it.
- Reset mid-operation: immediate return to FILL; partial block and ciphertext discarded; enable_encrypt deasserts asynchronously.
- Latency: last input byte accept -> first byte_out_valid = 1 (START) + 1 (min WAIT_BUSY) + core cycles + 1 capture.

Decomposition:
- Shared package aes_pkg:
  - typedef state_t for the FSM
  - typedef block_t = logic [127:0]
  - constants AES_BLOCK_BYTES=16 and AES_BLOCK_BITS=128
- One natural sub-module: flex_counter (existing), reused for the 4-bit byte index with rollover_val 15. The timeout counter is inline.

Test Plan:
- Feed bytes 00 11 22 .. ff with valid every cycle; core is the real encryption block with key 000102..0f -> data_to_core = 00112233445566778899aabbccddeeff; one enable_encrypt pulse; byte_out sequence 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- Same vector with byte_in_valid toggling 1/0 and byte_out_ready low 3 of every 4 cycles -> identical bytes; byte_out stable while stalled; no lost or duplicated bytes.
- Two back-to-back blocks: all 00, then all ff -> byte_in_ready=0 from START through DRAIN; second block's plaintext captured correctly; two distinct ciphertexts out.
- Core stub never raises enc_busy -> timeout_err=1 after 31 WAIT_BUSY cycles; byte_in_ready and byte_out_valid stay 0; reset clears the error.
- Assert n_rst low after 7 bytes, then send the full vector -> output matches the first scenario exactly; no stale bytes.
- Core stub holds enc_busy high already in the START cycle -> still proceeds to WAIT_DONE; ciphertext captured on enc_busy falling edge.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types and constants for the AES block packer
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;
  localparam int AES_BLOCK_BITS  = 128;

  typedef logic [AES_BLOCK_BITS-1:0] block_t;

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_DRAIN,
    S_ERROR
  } state_t;

  // Byte idx 0 maps to bits [127:120] (FIPS-197 byte order).
  function automatic logic [6:0] byte_msb(input logic [3:0] idx);
    return 7'd127 - {idx, 3'b000};
  endfunction

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - enable/clear counter that wraps to 0 after rollover_val
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;

  assign count_out     = r_count;
  assign rollover_flag = (r_count == rollover_val);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_enable) begin
      if (rollover_flag) r_count <= '0;
      else               r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_block_packer.sv
// rtl/aes_block_packer.sv - packs 16 SD bytes into an AES block, runs the core, streams ciphertext out
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int NUM_BYTES    = 16,
  parameter int BUSY_TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_in_valid,
  output logic         byte_in_ready,
  output logic         enable_encrypt,
  output logic [127:0] data_to_core,
  input  logic         enc_busy,
  input  logic [127:0] core_data_out,
  output logic [7:0]   byte_out,
  output logic         byte_out_valid,
  input  logic         byte_out_ready,
  output logic         packer_busy,
  output logic         timeout_err
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  state_t         r_state;
  block_t         r_plain;
  block_t         r_cipher;
  logic [TW-1:0]  r_tcnt;
  logic           r_in_ready;
  logic           r_enable;
  logic           r_out_valid;
  logic           r_busy;
  logic           r_err;

  logic [3:0]     w_idx;
  logic           w_idx_last;
  logic           w_in_fire;
  logic           w_out_fire;
  logic [6:0]     w_msb;
  logic [TW-1:0]  w_tcnt_inc;
  logic           w_tcnt_hit;

  assign w_in_fire  = byte_in_valid && r_in_ready;
  assign w_out_fire = byte_out_ready && r_out_valid;
  assign w_msb      = byte_msb(w_idx);
  assign w_tcnt_inc = r_tcnt + TW'(1);
  assign w_tcnt_hit = (w_tcnt_inc == TW'(BUSY_TIMEOUT));

  // One index serves both the fill and drain phases; they never overlap.
  flex_counter #(.NUM_CNT_BITS(4)) u_idx (
    .clk           (clk),
    .n_rst         (n_rst),
    .clear         (1'b0),
    .count_enable  (w_in_fire || w_out_fire),
    .rollover_val  (4'(NUM_BYTES - 1)),
    .count_out     (w_idx),
    .rollover_flag (w_idx_last)
  );

  assign byte_in_ready  = r_in_ready;
  assign enable_encrypt = r_enable;
  assign data_to_core   = r_plain;
  assign byte_out       = r_cipher[w_msb -: 8];
  assign byte_out_valid = r_out_valid;
  assign packer_busy    = r_busy;
  assign timeout_err    = r_err;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state     <= S_FILL;
      r_plain     <= '0;
      r_cipher    <= '0;
      r_tcnt      <= '0;
      r_in_ready  <= 1'b0;
      r_enable    <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          r_in_ready <= 1'b1;
          if (w_in_fire) begin
            r_plain[w_msb -: 8] <= byte_in;
            if (w_idx_last) begin
              r_state    <= S_START;
              r_in_ready <= 1'b0;
              r_enable   <= 1'b1;
              r_busy     <= 1'b1;
            end
          end
        end
        S_START: begin
          r_enable <= 1'b0;
          r_tcnt   <= '0;
          r_state  <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (enc_busy) begin
            r_tcnt  <= '0;
            r_state <= S_WAIT_DONE;
          end else if (w_tcnt_hit) begin
            r_tcnt  <= '0;
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        S_WAIT_DONE: begin
          if (!enc_busy) begin
            r_cipher    <= core_data_out;
            r_out_valid <= 1'b1;
            r_tcnt      <= '0;
            r_state     <= S_DRAIN;
          end else if (w_tcnt_hit) begin
            r_tcnt  <= '0;
            r_err   <= 1'b1;
            r_state <= S_ERROR;
          end else begin
            r_tcnt <= w_tcnt_inc;
          end
        end
        S_DRAIN: begin
          if (w_out_fire && w_idx_last) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_FILL;
          end
        end
        S_ERROR: begin
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_block_packer.sv
// tb/tb_aes_block_packer.sv - scoreboard bench for aes_block_packer with a behavioural core stub
module tb_aes_block_packer;

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MIX_K  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;

  logic         clk;
  logic         n_rst;
  logic [7:0]   byte_in;
  logic         byte_in_valid;
  logic         byte_in_ready;
  logic         enable_encrypt;
  logic [127:0] data_to_core;
  logic         enc_busy;
  logic [127:0] core_data_out;
  logic [7:0]   byte_out;
  logic         byte_out_valid;
  logic         byte_out_ready;
  logic         packer_busy;
  logic         timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;
  int stub_mode  = 0;   // 0 normal, 1 never busy, 2 busy already high
  int ready_mode = 0;   // 0 always, 1 one in four, 2 random
  logic [127:0] pt_q[$];
  logic [7:0]   exp_q[$];

  aes_block_packer #(.NUM_BYTES(16), .BUSY_TIMEOUT(31)) dut (
    .clk            (clk),
    .n_rst          (n_rst),
    .byte_in        (byte_in),
    .byte_in_valid  (byte_in_valid),
    .byte_in_ready  (byte_in_ready),
    .enable_encrypt (enable_encrypt),
    .data_to_core   (data_to_core),
    .enc_busy       (enc_busy),
    .core_data_out  (core_data_out),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .packer_busy    (packer_busy),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (got running, required finished)");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got condition false required true", name);
  endtask

  // Stand-in for the cipher: the known answer, otherwise an invertible scramble.
  function automatic logic [127:0] core_model(input logic [127:0] pt);
    if (pt == KAT_PT) return KAT_CT;
    return {pt[62:0], pt[127:63]} ^ MIX_K;
  endfunction

  task automatic push_exp(input logic [127:0] ct);
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
  endtask

  task automatic send_block(input logic [127:0] blk, input int gap, input int nbytes);
    int guard;
    if (nbytes == 16) pt_q.push_back(blk);
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0 && (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1))) begin
        byte_in_valid = 1'b0;
        byte_in = 8'($urandom);
        @(negedge clk);
      end
      byte_in = blk[127-8*i -: 8];
      byte_in_valid = 1'b1;
      guard = 0;
      while (!byte_in_ready && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 300) begin
        fail_now("byte_in_ready_wait");
        byte_in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    byte_in_valid = 1'b0;
    byte_in = 8'($urandom);
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((exp_q.size() != 0 || packer_busy) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 2000) fail_now("drain_wait");
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  128'(byte_in_ready),  128'(0));
    chk({tag, "_enable"},    128'(enable_encrypt), 128'(0));
    chk({tag, "_out_valid"}, 128'(byte_out_valid), 128'(0));
    chk({tag, "_busy"},      128'(packer_busy),    128'(0));
    chk({tag, "_err"},       128'(timeout_err),    128'(0));
    chk({tag, "_data"},      data_to_core,         128'(0));
    chk({tag, "_byte_out"},  128'(byte_out),       128'(0));
  endtask

  // Core stub: reacts to the enable pulse, presents junk while busy.
  initial begin
    logic [127:0] pt;
    enc_busy = 1'b0;
    core_data_out = '0;
    forever begin
      @(negedge clk);
      if (n_rst && enable_encrypt && stub_mode != 1) begin
        pt = data_to_core;
        if (stub_mode == 0) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          enc_busy = 1'b1;
          core_data_out = {$urandom, $urandom, $urandom, $urandom};
        end
        repeat ($urandom_range(2, 10)) @(negedge clk);
        chk("data_to_core_stable", data_to_core, pt);
        enc_busy = 1'b0;
        core_data_out = core_model(pt);
        @(negedge clk);
        core_data_out = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // Monitor: pops expectations on every completed handshake.
  initial begin
    logic       last_valid = 1'b0;
    logic       last_ready = 1'b0;
    logic       prev_en    = 1'b0;
    logic [7:0] last_byte  = '0;
    logic       r;
    int         cyc = 0;
    byte_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!n_rst) begin
        last_valid = 1'b0;
        last_ready = 1'b0;
        prev_en    = 1'b0;
      end else begin
        if (enable_encrypt) begin
          if (prev_en) viol++;
          if (pt_q.size() == 0) fail_now("enable_unexpected");
          else chk("data_to_core_at_enable", data_to_core, pt_q.pop_front());
        end
        prev_en = enable_encrypt;
        if (byte_in_ready && (enable_encrypt || byte_out_valid || timeout_err)) viol++;
        if (last_valid && last_ready) begin
          if (exp_q.size() == 0) fail_now("byte_out_unexpected");
          else chk("byte_out", 128'(last_byte), 128'(exp_q.pop_front()));
        end else if (last_valid) begin
          if (!byte_out_valid || byte_out !== last_byte) viol++;
        end
        last_valid = byte_out_valid;
        last_byte  = byte_out;
        case (ready_mode)
          0:       r = 1'b1;
          1:       r = (cyc % 4 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        byte_out_ready = r;
        last_ready = r;
        cyc++;
      end
    end
  end

  initial begin
    logic [127:0] blk;
    n_rst = 1'b0;
    byte_in = '0;
    byte_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    n_rst = 1'b1;

    // Known-answer vector, no stalls.
    push_exp(KAT_CT);
    send_block(KAT_PT, 0, 16);
    wait_idle();

    // Same vector, toggling valid and heavily stalled output.
    ready_mode = 1;
    push_exp(KAT_CT);
    send_block(KAT_PT, 1, 16);
    wait_idle();

    // Back-to-back all-zero and all-one blocks.
    ready_mode = 0;
    push_exp(core_model('0));
    push_exp(core_model('1));
    send_block('0, 0, 16);
    send_block('1, 0, 16);
    wait_idle();

    // Random blocks, random gaps and random backpressure.
    ready_mode = 2;
    for (int k = 0; k < 4; k++) begin
      blk = {$urandom, $urandom, $urandom, $urandom};
      push_exp(core_model(blk));
      send_block(blk, 2, 16);
    end
    wait_idle();

    // Core busy already high before the start pulse.
    ready_mode = 0;
    stub_mode = 2;
    enc_busy = 1'b1;
    core_data_out = {$urandom, $urandom, $urandom, $urandom};
    blk = {$urandom, $urandom, $urandom, $urandom};
    push_exp(core_model(blk));
    send_block(blk, 0, 16);
    wait_idle();
    stub_mode = 0;

    // Reset after a partial block, then the full vector.
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 7);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    n_rst = 1'b1;
    push_exp(KAT_CT);
    send_block(KAT_PT, 0, 16);
    wait_idle();

    // Core never answers: timeout after 31 WAIT_BUSY cycles.
    stub_mode = 1;
    send_block({$urandom, $urandom, $urandom, $urandom}, 0, 16);
    chk("start_after_last_byte", 128'(enable_encrypt), 128'(1));
    repeat (31) @(negedge clk);
    chk("timeout_not_yet", 128'(timeout_err), 128'(0));
    @(negedge clk);
    chk("timeout_err_set", 128'(timeout_err), 128'(1));
    byte_in_valid = 1'b1;
    repeat (4) @(negedge clk);
    chk("error_in_ready", 128'(byte_in_ready), 128'(0));
    chk("error_out_valid", 128'(byte_out_valid), 128'(0));
    chk("error_sticky", 128'(timeout_err), 128'(1));
    byte_in_valid = 1'b0;
    n_rst = 1'b0;
    #1 chk("error_cleared", 128'(timeout_err), 128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    stub_mode = 0;
    repeat (2) @(negedge clk);

    chk("protocol_violations", 128'(viol), 128'(0));
    chk("exp_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("pt_queue_empty", 128'(pt_q.size()), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
